// File: rtl/openram_gpio_pkg.sv
// Shared types and defaults for the GPIO packet link.
// Build option: GPIO_LINK_PARITY_EN adds an even-parity bit to both RX and TX frames.
package openram_gpio_pkg;

  localparam int unsigned PACKET_W_DEF = 86;
  localparam int unsigned RESULT_W_DEF = 64;
  localparam int unsigned PARITY_MAX_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
`ifdef GPIO_LINK_PARITY_EN
    CHECK,
`endif
    STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef GPIO_LINK_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_e;

  // Callers zero-extend their word; leading zeros do not change the parity.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/gpio_result_serializer.sv
// TX path: accepts one result word and sends start, data MSB first, optional parity, stop.
// Build option: GPIO_LINK_PARITY_EN inserts the parity bit before the stop bit.
module gpio_result_serializer
  import openram_gpio_pkg::*;
#(
  parameter int unsigned RESULT_W = RESULT_W_DEF
) (
  input  logic                gpio_clk,
  input  logic                reset_n,
  input  logic [RESULT_W-1:0] result,
  input  logic                result_valid,
  output logic                result_ready,
  output logic                gpio_tx
);

  localparam int unsigned CNT_W = (RESULT_W > 1) ? $clog2(RESULT_W) : 1;

  tx_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RESULT_W-1:0] shift_q, shift_d;
  logic                par_q, par_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    result_ready = 1'b0;
    gpio_tx      = 1'b0;
    case (state_q)
      TX_IDLE: begin
        result_ready = 1'b1;
        if (result_valid) begin
          shift_d = result;
          par_d   = even_parity(PARITY_MAX_W'(result));
          cnt_d   = '0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        gpio_tx = 1'b1;
        state_d = TX_DATA;
      end
      TX_DATA: begin
        gpio_tx = shift_q[RESULT_W-1];
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(RESULT_W - 1)) begin
`ifdef GPIO_LINK_PARITY_EN
          state_d = TX_PARITY;
`else
          state_d = TX_STOP;
`endif
        end
      end
`ifdef GPIO_LINK_PARITY_EN
      TX_PARITY: begin
        gpio_tx = par_q;
        state_d = TX_STOP;
      end
`endif
      TX_STOP: begin
        gpio_tx = 1'b0;
        state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge gpio_clk) begin
    if (!reset_n) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

endmodule

// File: rtl/gpio_packet_link.sv
// Serial command receiver (start, PACKET_W bits MSB first, stop 0) plus result serializer.
// Build option: GPIO_LINK_PARITY_EN adds an even-parity bit after the payload.
module gpio_packet_link
  import openram_gpio_pkg::*;
#(
  parameter int unsigned PACKET_W = PACKET_W_DEF,
  parameter int unsigned RESULT_W = RESULT_W_DEF
) (
  input  logic                gpio_clk,
  input  logic                reset_n,
  input  logic                gpio_rx,
  output logic [PACKET_W-1:0] packet,
  output logic                packet_valid,
  output logic                frame_err,
  input  logic [RESULT_W-1:0] result,
  input  logic                result_valid,
  output logic                result_ready,
  output logic                gpio_tx,
  output logic                tx_busy
);

  localparam int unsigned CNT_W = (PACKET_W > 1) ? $clog2(PACKET_W) : 1;

  rx_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PACKET_W-1:0] shift_q, shift_d;
  logic [PACKET_W-1:0] packet_q, packet_d;
  logic                packet_valid_q, packet_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                perr_q, perr_d;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shift_d        = shift_q;
    packet_d       = packet_q;
    packet_valid_d = 1'b0;
    frame_err_d    = 1'b0;
    perr_d         = perr_q;
    case (state_q)
      IDLE: begin
        if (gpio_rx) begin
          cnt_d   = '0;
          perr_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = {shift_q[PACKET_W-2:0], gpio_rx};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(PACKET_W - 1)) begin
`ifdef GPIO_LINK_PARITY_EN
          state_d = CHECK;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef GPIO_LINK_PARITY_EN
      CHECK: begin
        perr_d  = gpio_rx ^ even_parity(PARITY_MAX_W'(shift_q));
        state_d = STOP;
      end
`endif
      STOP: begin
        // A parity mismatch is only reported once the stop bit has been consumed.
        if (gpio_rx || perr_q) begin
          frame_err_d = 1'b1;
        end else begin
          packet_d       = shift_q;
          packet_valid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gpio_clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      shift_q        <= '0;
      packet_q       <= '0;
      packet_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
      perr_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      packet_q       <= packet_d;
      packet_valid_q <= packet_valid_d;
      frame_err_q    <= frame_err_d;
      perr_q         <= perr_d;
    end
  end

  assign packet       = packet_q;
  assign packet_valid = packet_valid_q;
  assign frame_err    = frame_err_q;

  gpio_result_serializer #(
    .RESULT_W(RESULT_W)
  ) u_tx (
    .gpio_clk    (gpio_clk),
    .reset_n     (reset_n),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .gpio_tx     (gpio_tx)
  );

  assign tx_busy = ~result_ready;

endmodule

// File: tb/tb_gpio_packet_link.sv
// Directed and randomized bench for gpio_packet_link against a frame-level model.
// Build option: GPIO_LINK_PARITY_EN enables the parity-frame steps.
module tb_gpio_packet_link;

  localparam int unsigned PW = 86;
  localparam int unsigned RW = 64;

  logic          gpio_clk = 1'b0;
  logic          reset_n;
  logic          gpio_rx;
  logic [PW-1:0] packet;
  logic          packet_valid;
  logic          frame_err;
  logic [RW-1:0] result;
  logic          result_valid;
  logic          result_ready;
  logic          gpio_tx;
  logic          tx_busy;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [PW-1:0] exp_packet;

  gpio_packet_link #(
    .PACKET_W(PW),
    .RESULT_W(RW)
  ) dut (
    .gpio_clk    (gpio_clk),
    .reset_n     (reset_n),
    .gpio_rx     (gpio_rx),
    .packet      (packet),
    .packet_valid(packet_valid),
    .frame_err   (frame_err),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .gpio_tx     (gpio_tx),
    .tx_busy     (tx_busy)
  );

  always #5 gpio_clk = ~gpio_clk;

  task automatic tick();
    @(posedge gpio_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand_payload();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[PW-1:0];
  endfunction

  // Frame model: bits are start, payload MSB first, optional parity, stop.
  // A frame is accepted only when stop is 0 and (if present) parity makes the count of ones even.
  task automatic send_frame(input logic [PW-1:0] payload, input logic stop_bit, input logic par_bit);
    logic bits[$];
    logic good;
    bits.push_back(1'b1);
    for (int i = PW - 1; i >= 0; i--) bits.push_back(payload[i]);
    good = (stop_bit == 1'b0);
`ifdef GPIO_LINK_PARITY_EN
    bits.push_back(par_bit);
    if (par_bit != (^payload)) good = 1'b0;
`else
    if (par_bit) good = good;
`endif
    bits.push_back(stop_bit);
    if (good) exp_packet = payload;
    for (int k = 0; k < bits.size(); k++) begin
      gpio_rx = bits[k];
      tick();
      if (k == bits.size() - 1) begin
        check("rx_packet_valid_end", 128'(packet_valid), 128'(good));
        check("rx_frame_err_end", 128'(frame_err), 128'(!good));
      end else begin
        check("rx_no_pulse_mid", 128'({packet_valid, frame_err}), 128'(0));
      end
    end
    check("rx_packet", 128'(packet), 128'(exp_packet));
    gpio_rx = 1'b0;
  endtask

  task automatic send_result(input logic [RW-1:0] word);
    logic bits[$];
    int unsigned wait_cnt;
    result       = word;
    result_valid = 1'b1;
    wait_cnt     = 0;
    while (!result_ready && wait_cnt < 200) begin
      tick();
      wait_cnt++;
    end
    check("tx_ready_wait", 128'(result_ready), 128'(1));
    tick();
    // Source changes value and valid while busy; the word in flight must not change.
    result       = {$urandom, $urandom};
    result_valid = 1'($urandom);
    bits.push_back(1'b1);
    for (int i = RW - 1; i >= 0; i--) bits.push_back(word[i]);
`ifdef GPIO_LINK_PARITY_EN
    bits.push_back(^word);
`endif
    bits.push_back(1'b0);
    for (int k = 0; k < bits.size(); k++) begin
      check("tx_bit", 128'(gpio_tx), 128'(bits[k]));
      check("tx_busy_ready", 128'({result_ready, tx_busy}), 128'(2'b01));
      tick();
    end
    check("tx_ready_after", 128'({result_ready, tx_busy, gpio_tx}), 128'(3'b100));
    result_valid = 1'b0;
  endtask

  initial begin
    logic [PW-1:0] p;
    reset_n      = 1'b0;
    gpio_rx      = 1'b0;
    result       = '0;
    result_valid = 1'b0;
    exp_packet   = '0;
    tick();
    tick();
    check("reset_outputs", 128'({packet_valid, frame_err, gpio_tx, result_ready, tx_busy}),
          128'(5'b00010));
    check("reset_packet", 128'(packet), 128'(0));
    reset_n = 1'b1;
    tick();

    p = {3'd0, 28'd0, 1'b0, 1'b0, 4'hF, 8'd1, 32'd1, 1'b0, 8'd0};
    send_frame(p, 1'b0, ^p);
    send_frame(~p, 1'b1, ^(~p));

    send_result(64'h8000_0000_0000_0005);

    // Back-to-back: no idle cycle between frames.
    for (int n = 0; n < 4; n++) begin
      p = rand_payload();
      send_frame(p, 1'b0, ^p);
    end

    // Reset in the middle of a frame, at payload bit 40.
    p = rand_payload();
    gpio_rx = 1'b1;
    tick();
    for (int i = PW - 1; i > PW - 1 - 40; i--) begin
      gpio_rx = p[i];
      tick();
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    gpio_rx = 1'b0;
    exp_packet = '0;
    check("reset_mid_pulses", 128'({packet_valid, frame_err}), 128'(0));
    check("reset_mid_packet", 128'(packet), 128'(0));
    for (int k = 0; k < 5; k++) begin
      tick();
      check("reset_mid_quiet", 128'({packet_valid, frame_err}), 128'(0));
    end
    p = rand_payload();
    send_frame(p, 1'b0, ^p);

`ifdef GPIO_LINK_PARITY_EN
    send_frame(86'd1, 1'b0, 1'b0);
    send_frame(86'd1, 1'b0, 1'b1);
`endif

    // Randomized mix, with RX and TX running concurrently.
    for (int n = 0; n < 6; n++) begin
      logic [PW-1:0] rp;
      logic          rs;
      logic          rpar;
      logic [RW-1:0] rw;
      rp   = rand_payload();
      rs   = ($urandom_range(0, 3) == 0);
      rpar = ($urandom_range(0, 3) == 0) ? ~(^rp) : ^rp;
      rw   = {$urandom, $urandom};
      fork
        send_frame(rp, rs, rpar);
        send_result(rw);
      join
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
